// File: rtl/if_id_stage_if.sv
// IF/ID handshake bundle: fetch-side input channel, decode-side output channel.
// slave is the pipeline-register view, master is the fetch/decode driver view.
interface if_id_stage_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic        out_ready;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  in_pc,
        output in_ready,
        input  flush,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_npc,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_instr,
        output in_pc,
        input  in_ready,
        output flush,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_npc,
        output out_ready
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: two-entry skid buffer with registered in_ready.
// Optional stall counter output enabled by macro IF_ID_STALL_CNT_EN.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h6000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input logic          clk,
    input logic          rst,
    if_id_stage_if.slave bus
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        ready_q;
    logic [31:0] main_instr_q;
    logic [31:0] main_instr_d;
    logic [31:0] main_pc_q;
    logic [31:0] main_pc_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_instr_d;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_pc_d;
    logic        valid;
    logic        acc_in;
    logic        acc_out;

    assign valid   = (state_q != EMPTY);
    assign acc_in  = bus.in_valid & ready_q;
    assign acc_out = valid & bus.out_ready;

    // main_pc is left untouched when the stage empties so out_pc holds
    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? main_instr_q : NOP_INSTR;
    assign bus.out_pc    = main_pc_q;
    assign bus.out_npc   = main_pc_q + PC_STEP;

    // Next-state and datapath selection; flush drops everything held
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        main_instr_d = bus.in_instr;
                        main_pc_d    = bus.in_pc;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_instr_d = bus.in_instr;
                        main_pc_d    = bus.in_pc;
                    end else if (acc_in) begin
                        skid_instr_d = bus.in_instr;
                        skid_pc_d    = bus.in_pc;
                        state_d      = TWO;
                    end else if (acc_out) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (acc_out) begin
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; in_ready is precomputed from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            ready_q      <= 1'b1;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d != TWO);
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    // Saturating count of cycles decode holds a valid instruction back
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (valid && !bus.out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed vector table, streaming run,
// and random traffic checked against a queue-based reference model.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h6000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    if_id_stage_if bus ();

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    if_id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_last_pc;
    int          m_sc;

    typedef struct {
        bit          r;
        bit          iv;
        logic [31:0] instr;
        logic [31:0] pc;
        bit          fl;
        bit          ordy;
        bit          e_valid;
        bit          e_ready;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(bit r, bit iv, logic [31:0] ins,
                                logic [31:0] pc, bit fl, bit ordy,
                                bit ev, bit er, logic [31:0] ei,
                                logic [31:0] ep, logic [31:0] en);
        vec_t v;
        v.r = r; v.iv = iv; v.instr = ins; v.pc = pc;
        v.fl = fl; v.ordy = ordy;
        v.e_valid = ev; v.e_ready = er; v.e_instr = ei;
        v.e_pc = ep; v.e_npc = en;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two accepted words
    task automatic model_step(bit r, bit iv, logic [31:0] ins,
                              logic [31:0] pc, bit fl, bit ordy);
        bit   a_in;
        bit   a_out;
        ent_t e;
        if (r) begin
            mq.delete();
            m_last_pc = 32'd0;
            m_sc = 0;
        end else begin
            a_in  = iv && (mq.size() < 2);
            a_out = ordy && (mq.size() > 0);
            if (mq.size() > 0 && !ordy && m_sc < 65535) m_sc++;
            if (fl) begin
                mq.delete();
            end else begin
                if (a_out) void'(mq.pop_front());
                if (a_in) begin
                    e.instr = ins;
                    e.pc = pc;
                    mq.push_back(e);
                end
            end
            if (mq.size() > 0) m_last_pc = mq[0].pc;
        end
    endtask

    task automatic apply(bit r, bit iv, logic [31:0] ins,
                         logic [31:0] pc, bit fl, bit ordy);
        rst          = r;
        bus.in_valid = iv;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        bus.flush    = fl;
        bus.out_ready = ordy;
        model_step(r, iv, ins, pc, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(string tag);
        logic [31:0] ei;
        ei = (mq.size() > 0) ? mq[0].instr : NOP;
        chk({tag, "_valid"}, {31'd0, bus.out_valid},
            {31'd0, mq.size() > 0});
        chk({tag, "_ready"}, {31'd0, bus.in_ready},
            {31'd0, mq.size() < 2});
        chk({tag, "_instr"}, bus.out_instr, ei);
        chk({tag, "_pc"}, bus.out_pc, m_last_pc);
        chk({tag, "_npc"}, bus.out_npc, m_last_pc + 32'd4);
`ifdef IF_ID_STALL_CNT_EN
        chk({tag, "_stall"}, {16'd0, stall_cnt}, m_sc[31:0]);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_last_pc = 32'd0;
        m_sc = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.in_pc = 32'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0]  = mk(1,0,0,0,0,0, 0,1,NOP,32'h0,32'h4);
        vecs[1]  = mk(1,0,0,0,0,0, 0,1,NOP,32'h0,32'h4);
        vecs[2]  = mk(0,1,32'hAAAA0001,32'h100,0,0,
                      1,1,32'hAAAA0001,32'h100,32'h104);
        vecs[3]  = mk(0,1,32'hBBBB0002,32'h104,0,0,
                      1,0,32'hAAAA0001,32'h100,32'h104);
        vecs[4]  = mk(0,1,32'hCCCC0003,32'h108,0,0,
                      1,0,32'hAAAA0001,32'h100,32'h104);
        vecs[5]  = mk(0,0,0,0,0,1,
                      1,1,32'hBBBB0002,32'h104,32'h108);
        vecs[6]  = mk(0,0,0,0,0,1, 0,1,NOP,32'h104,32'h108);
        vecs[7]  = mk(0,1,32'hDDDD0004,32'h200,0,0,
                      1,1,32'hDDDD0004,32'h200,32'h204);
        vecs[8]  = mk(0,1,32'hEEEE0005,32'h204,0,0,
                      1,0,32'hDDDD0004,32'h200,32'h204);
        vecs[9]  = mk(0,1,32'hC0C0C0C0,32'h300,1,0,
                      0,1,NOP,32'h200,32'h204);
        vecs[10] = mk(0,0,0,0,0,1, 0,1,NOP,32'h200,32'h204);
        vecs[11] = mk(0,1,32'hF0F00006,32'h400,0,0,
                      1,1,32'hF0F00006,32'h400,32'h404);
        vecs[12] = mk(0,1,32'h60600007,32'h404,0,0,
                      1,0,32'hF0F00006,32'h400,32'h404);
        vecs[13] = mk(1,1,32'h12345678,32'h408,1,1,
                      0,1,NOP,32'h0,32'h4);
        vecs[14] = mk(0,1,32'h0BAD0008,32'hFFFFFFFC,0,1,
                      1,1,32'h0BAD0008,32'hFFFFFFFC,32'h0);
        vecs[15] = mk(0,0,0,0,0,1, 0,1,NOP,32'hFFFFFFFC,32'h0);
        vecs[16] = mk(0,1,32'h11110009,32'h500,0,0,
                      1,1,32'h11110009,32'h500,32'h504);
        vecs[17] = mk(0,1,32'h2222000A,32'h504,1,1,
                      0,1,NOP,32'h500,32'h504);

        // streaming
        apply(1,0,0,0,0,1);
        apply(1,0,0,0,0,1);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_instr", bus.out_instr, NOP);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_npc", bus.out_npc, 32'd4);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc;
            pc = 32'h0040_0000 + 32'(i) * 4;
            apply(0,1,32'hA000_0000 + 32'(i),pc,0,1);
            chk("strm_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("strm_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("strm_instr", bus.out_instr, 32'hA000_0000 + 32'(i));
            chk("strm_pc", bus.out_pc, pc);
            chk("strm_npc", bus.out_npc, pc + 32'd4);
        end

        // directed table
        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].r, vecs[i].iv, vecs[i].instr, vecs[i].pc,
                  vecs[i].fl, vecs[i].ordy);
            chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid},
                {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_ready", i), {31'd0, bus.in_ready},
                {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_npc", i), bus.out_npc, vecs[i].e_npc);
        end

        // random traffic against the model
        apply(1,0,0,0,0,0);
        chk_model("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit iv;
            bit fl;
            bit ordy;
            r    = ($urandom_range(0, 199) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            apply(r, iv, $urandom, $urandom & 32'hFFFF_FFFC, fl, ordy);
            chk_model("rnd");
        end

`ifdef IF_ID_STALL_CNT_EN
        apply(1,0,0,0,0,0);
        chk("sc_rst", {16'd0, stall_cnt}, 32'd0);
        apply(0,1,32'h5555_0001,32'h800,0,0);
        for (int i = 0; i < 70000; i++) apply(0,0,0,0,0,0);
        chk("sc_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        apply(0,0,0,0,0,1);
        apply(0,0,0,0,0,1);
        chk("sc_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        apply(0,1,32'h5555_0002,32'h804,1,0);
        chk("sc_flush", {16'd0, stall_cnt}, 32'h0000_FFFF);
        apply(1,0,0,0,0,0);
        chk("sc_clr", {16'd0, stall_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h6000_0000, the word presented on out_instr whenever out_valid is 0.
REQ-002 The block SHALL have parameter PC_STEP, default 32'd4, the increment used to form out_npc.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, fetch stage presents an instruction.
REQ-006 The block SHALL have port in_instr, input, 32, fetched instruction word.
REQ-007 The block SHALL have port in_pc, input, 32, byte address of in_instr.
REQ-008 The block SHALL have port in_ready, output, 1, the stage accepts in_instr this cycle.
REQ-009 The block SHALL have port flush, input, 1, discard all held instructions (taken branch or redirect).
REQ-010 The block SHALL have port out_valid, output, 1, decode-side instruction valid.
REQ-011 The block SHALL have port out_instr, output, 32, instruction to decode.
REQ-012 The block SHALL have port out_pc, output, 32, address of out_instr.
REQ-013 The block SHALL have port out_npc, output, 32, out_pc + PC_STEP, modulo 2^32.
REQ-014 The block SHALL have port out_ready, input, 1, decode consumes out_instr this cycle.

Function
REQ-015 The block SHALL hold up to two entries: a main register driving the outputs and a skid register, in states EMPTY, ONE and TWO.
REQ-016 An input handshake SHALL occur when in_valid and in_ready; an output handshake SHALL occur when out_valid and out_ready.
REQ-017 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, and 0 in TWO; it has no combinational path from out_ready.
REQ-018 In EMPTY, an input handshake SHALL load main and move to ONE; out_valid asserts the next cycle (latency 1).
REQ-019 In ONE, an input handshake with an output handshake SHALL replace main and stay in ONE; an input handshake alone SHALL load skid and move to TWO; an output handshake alone SHALL move to EMPTY.
REQ-020 In TWO, an output handshake SHALL move skid into main and go to ONE; no input is accepted in TWO.
REQ-021 Order SHALL be preserved: instructions leave in acceptance order with no loss or duplication.
REQ-022 out_instr, out_pc and out_npc SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 When out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc and out_npc SHALL hold their last values.
REQ-024 flush=1 SHALL move the block to EMPTY at the next edge from any state, discard both entries and any same-cycle input, and leave in_ready=1 the following cycle.
REQ-025 flush SHALL override simultaneous input and output handshakes; the output handshake in the flush cycle still counts as consumed by decode.
REQ-026 out_npc SHALL wrap: in_pc=32'hFFFF_FFFC gives out_npc=32'h0000_0000.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL go to EMPTY with out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0 and out_npc=PC_STEP.
REQ-028 rst SHALL take priority over flush and all handshakes; reset mid-operation discards both entries.

Configuration
REQ-029 With macro IF_ID_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits) that increments each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, is cleared only by rst, and resets to 0.
REQ-030 Without IF_ID_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover streaming. Stimulus: rst for 2 cycles, then in_pc=0x00400000, 0x00400004, … with in_valid=1 and out_ready=1 held for 8 cycles. Required response: each word appears one cycle later, out_npc=out_pc+4, and in_ready stays 1.
REQ-032 The bench SHALL cover backpressure. Stimulus: out_ready=0 while A and B are offered. Required response: state TWO, in_ready=0, out_instr=A held. Stimulus: release out_ready. Required response: A, then B, then EMPTY.
REQ-033 The bench SHALL cover flush in TWO. Stimulus: flush=1 with in_valid=1 (word C). Required response: next cycle out_valid=0, out_instr=0x60000000, in_ready=1, and C is never emitted.
REQ-034 The bench SHALL cover reset mid-stall. Stimulus: rst=1 in state TWO. Required response: next cycle out_valid=0, out_pc=0, out_npc=4, in_ready=1.
REQ-035 The bench SHALL cover wrap. Stimulus: in_pc=0xFFFFFFFC. Required response: out_npc=0x00000000.
REQ-036 The bench SHALL cover the stall counter when IF_ID_STALL_CNT_EN is defined. Stimulus: 70000 consecutive stall cycles. Required response: stall_cnt=0xFFFF; it holds that value after the stall ends and clears only on rst.
